// File: rtl/lcd_hd44780_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_hd44780_pkg
//  Description : Shared types and constants for the HD44780 4-bit controller:
//                sequencer states, init ROM and long-running opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_hd44780_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT     = 3'd1,
    IDLE     = 3'd2,
    XFER     = 3'd3,
    WAIT     = 3'd4
  } lcd_state_t;

  // Full init bytes, index 0 sent first: function set, display on, entry mode, clear
  localparam logic [3:0][7:0] c_init_bytes = {8'h01, 8'h06, 8'h0C, 8'h28};
  // Single-nibble wake-up sequence, index 0 sent first
  localparam logic [3:0][3:0] c_init_nibs  = {4'h2, 4'h3, 4'h3, 4'h3};

  localparam logic [7:0] c_op_clear     = 8'h01;
  localparam logic [7:0] c_op_home      = 8'h02;
  localparam logic [7:0] c_op_home_alt  = 8'h03;

  // Steps 0..3 are single nibbles, 4..7 are full bytes
  localparam logic [2:0] c_last_init_step = 3'd7;

  function automatic logic [7:0] init_item(input logic [2:0] step);
    if (!step[2]) return {4'h0, c_init_nibs[step[1:0]]};
    return c_init_bytes[step[1:0]];
  endfunction

  // Clear and home need the long settle time; only as commands, never as data
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == c_op_clear || data == c_op_home || data == c_op_home_alt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_nibble_tx
//  Description : Drives one nibble onto the LCD bus: SETUP (1 cycle),
//                PULSE (E_CYC cycles, E high), HOLD (1 cycle). done is high
//                during HOLD so the next nibble can start back-to-back.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_nibble_tx #(
  parameter int E_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  localparam int EW = $clog2(E_CYC) + 1;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  generate
    if (E_CYC < 1) begin : g_bad_e_cyc
      $error("lcd_nibble_tx: E_CYC must be at least 1");
    end
  endgenerate

  logic [1:0]    r_phase;
  logic [1:0]    w_phase_next;
  logic [EW-1:0] r_e_cnt;
  logic          r_e;
  logic          r_rs;
  logic [3:0]    r_d;

  // Phase register
  always_ff @(posedge clk) begin
    if (!rst_n) r_phase <= PH_IDLE;
    else        r_phase <= w_phase_next;
  end

  // Phase sequencing; a start in HOLD chains straight into the next SETUP
  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      PH_IDLE, PH_HOLD: w_phase_next = start ? PH_SETUP : PH_IDLE;
      PH_SETUP:         w_phase_next = PH_PULSE;
      PH_PULSE:         w_phase_next = (r_e_cnt == '0) ? PH_HOLD : PH_PULSE;
      default:          w_phase_next = PH_IDLE;
    endcase
  end

  // Registered bus outputs and the E-width counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_d     <= 4'h0;
      r_e_cnt <= '0;
    end else begin
      r_e <= (w_phase_next == PH_PULSE);
      if (r_phase == PH_SETUP)
        r_e_cnt <= EW'(E_CYC - 1);
      else if (r_phase == PH_PULSE && r_e_cnt != '0)
        r_e_cnt <= r_e_cnt - 1'b1;
      if (w_phase_next == PH_SETUP) begin
        r_d  <= nib;
        r_rs <= rs;
      end
    end
  end

  assign done   = (r_phase == PH_HOLD);
  assign lcd_e  = r_e;
  assign lcd_rs = r_rs;
  assign lcd_d  = r_d;

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_hd44780_ctrl
//  Description : HD44780 4-bit controller. Runs the power-up init sequence,
//                then writes command/data bytes from a valid/ready port as
//                two nibbles followed by a per-command settle wait.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_hd44780_ctrl
  import lcd_hd44780_pkg::*;
#(
  parameter int POWERUP_CYC  = 1000000,
  parameter int E_CYC        = 16,
  parameter int INIT_GAP_CYC = 200000,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam int MAX_A   = (POWERUP_CYC > INIT_GAP_CYC) ? POWERUP_CYC : INIT_GAP_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > E_CYC) ? MAX_C : E_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] c_pwr_load = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] c_gap_load = CW'(INIT_GAP_CYC - 1);
  localparam logic [CW-1:0] c_cmd_load = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] c_clr_load = CW'(CLR_WAIT_CYC - 1);

  lcd_state_t    r_state;
  lcd_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_step;
  logic [7:0]    r_byte;
  logic          r_rs;
  logic          r_lo;
  logic          r_in_ready;
  logic          r_init_done;

  logic          w_cnt_zero;
  logic          w_single;
  logic          w_byte_done;
  logic [2:0]    w_item_idx;
  logic [7:0]    w_item;
  logic [3:0]    w_item_nib;
  logic [CW-1:0] w_wait_val;

  logic          w_tx_start;
  logic [3:0]    w_tx_nib;
  logic          w_tx_rs;
  logic          w_tx_done;
  logic          w_cnt_load;
  logic          w_item_load;
  logic          w_step_inc;
  logic          w_accept;
  logic          w_lo_set;

  assign w_cnt_zero  = (r_cnt == '0);
  // Init steps 0..3 are lone nibbles; everything after is a two-nibble byte
  assign w_single    = !r_init_done && !r_step[2];
  assign w_byte_done = w_tx_done && (r_lo || w_single);
  // In WAIT the next item is fetched; elsewhere the current one
  assign w_item_idx  = (r_state == WAIT) ? r_step + 3'd1 : r_step;
  assign w_item      = init_item(w_item_idx);
  assign w_item_nib  = w_item_idx[2] ? w_item[7:4] : w_item[3:0];
  assign w_wait_val  = w_single                  ? c_gap_load :
                       is_long_cmd(r_rs, r_byte) ? c_clr_load : c_cmd_load;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= PWR_WAIT;
    else        r_state <= w_state_next;
  end

  // Sequencing between power-up wait, init items, idle, transfers and waits
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PWR_WAIT: if (w_cnt_zero) w_state_next = INIT;
      INIT:     if (w_byte_done) w_state_next = WAIT;
      XFER:     if (w_byte_done) w_state_next = WAIT;
      WAIT: begin
        if (w_cnt_zero) begin
          if (r_init_done || r_step == c_last_init_step) w_state_next = IDLE;
          else                                           w_state_next = INIT;
        end
      end
      IDLE:     if (in_valid && r_in_ready) w_state_next = XFER;
      default:  w_state_next = PWR_WAIT;
    endcase
  end

  // Nibble launches, counter loads and datapath strobes
  always_comb begin
    w_tx_start  = 1'b0;
    w_tx_nib    = r_byte[3:0];
    w_tx_rs     = r_rs;
    w_cnt_load  = 1'b0;
    w_item_load = 1'b0;
    w_step_inc  = 1'b0;
    w_accept    = 1'b0;
    w_lo_set    = 1'b0;
    case (r_state)
      PWR_WAIT: begin
        if (w_cnt_zero) begin
          w_tx_start  = 1'b1;
          w_tx_nib    = w_item_nib;
          w_tx_rs     = 1'b0;
          w_item_load = 1'b1;
        end
      end
      INIT, XFER: begin
        if (w_byte_done) begin
          w_cnt_load = 1'b1;
        end else if (w_tx_done) begin
          w_tx_start = 1'b1;
          w_lo_set   = 1'b1;
        end
      end
      WAIT: begin
        if (w_cnt_zero && !r_init_done && r_step != c_last_init_step) begin
          w_tx_start  = 1'b1;
          w_tx_nib    = w_item_nib;
          w_tx_rs     = 1'b0;
          w_item_load = 1'b1;
          w_step_inc  = 1'b1;
        end
      end
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_tx_start = 1'b1;
          w_tx_nib   = in_data[7:4];
          w_tx_rs    = in_rs;
          w_accept   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shared delay counter, byte latch and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= c_pwr_load;
      r_step      <= 3'd0;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_lo        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      if (w_cnt_load)       r_cnt <= w_wait_val;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
      if (w_step_inc) r_step <= r_step + 3'd1;
      if (w_item_load) begin
        r_byte <= w_item;
        r_rs   <= 1'b0;
        r_lo   <= 1'b0;
      end
      if (w_accept) begin
        r_byte <= in_data;
        r_rs   <= in_rs;
        r_lo   <= 1'b0;
      end
      if (w_lo_set) r_lo <= 1'b1;
      r_in_ready <= (w_state_next == IDLE);
      if (w_state_next == IDLE) r_init_done <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign init_done = r_init_done;

  lcd_nibble_tx #(
    .E_CYC (E_CYC)
  ) u_nibble_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_tx_start),
    .nib    (w_tx_nib),
    .rs     (w_tx_rs),
    .done   (w_tx_done),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_d  (lcd_d)
  );

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lcd_hd44780_ctrl
//  Description : Directed self-checking bench for lcd_hd44780_ctrl with a
//                small-parameter build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_hd44780_ctrl;

  localparam int POWERUP_CYC  = 20;
  localparam int E_CYC        = 2;
  localparam int INIT_GAP_CYC = 10;
  localparam int CMD_WAIT_CYC = 5;
  localparam int CLR_WAIT_CYC = 30;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_rs    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_e;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .POWERUP_CYC  (POWERUP_CYC),
    .E_CYC        (E_CYC),
    .INIT_GAP_CYC (INIT_GAP_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_data   (in_data),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_d     (lcd_d)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {rs, nibble} captured at each E rise, and each E pulse width in cycles
  logic [4:0] nib_q[$];
  int         width_q[$];
  logic       e_prev  = 1'b0;
  int         e_width = 0;

  logic [3:0] exp_init [0:11] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                   4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

  // Bus monitor sampled on the falling edge
  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      nib_q.push_back({lcd_rs, lcd_d});
      e_width <= 1;
    end else if (lcd_e) begin
      e_width <= e_width + 1;
    end
    if (!lcd_e && e_prev) width_q.push_back(e_width);
    e_prev <= lcd_e;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    nib_q.delete();
    width_q.delete();
  endtask

  // Cycles from now until in_ready is seen high, bounded
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 400);
  endtask

  // Offer one byte while in_ready is high; it is taken on the next edge
  task automatic send(input logic rs, input logic [7:0] data);
    in_rs    = rs;
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_nibs(input string tag, input logic [4:0] exp [$]);
    check({tag, "_count"}, nib_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < nib_q.size(); i++)
      check($sformatf("%s_nib%0d", tag, i), nib_q[i], exp[i]);
    for (int i = 0; i < width_q.size(); i++)
      check($sformatf("%s_ewidth%0d", tag, i), width_q[i], E_CYC);
    clear_mon();
  endtask

  // Called at #1 after the last reset edge with rst_n just released
  task automatic run_init(input string tag);
    int n;
    logic [4:0] exp [$];
    n = 0;
    while (!lcd_e && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_first_e_rise"}, n, 21);
    // Traffic offered during init must be ignored
    in_rs    = 1'b1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
    end
    in_valid = 1'b0;
    while (!init_done && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_init_done_cycle"}, n, 153);
    check({tag, "_ready_after_init"}, in_ready, 1'b1);
    for (int i = 0; i < 12; i++) exp.push_back({1'b0, exp_init[i]});
    check_nibs(tag, exp);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_lcd_e", lcd_e, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_d", lcd_d, 4'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    rst_n = 1'b1;
    run_init("init1");

    // Data byte 0x48
    send(1'b1, 8'h48);
    check("d48_ready_low", in_ready, 1'b0);
    wait_ready(n);
    check("d48_ready_cycles", n, 13);
    check_nibs("d48", '{5'h14, 5'h18});

    // Clear command: long wait
    send(1'b0, 8'h01);
    wait_ready(n);
    check("clr_ready_cycles", n, 38);
    check_nibs("clr", '{5'h00, 5'h01});

    // Same byte as data: short wait
    send(1'b1, 8'h01);
    wait_ready(n);
    check("d01_ready_cycles", n, 13);
    check_nibs("d01", '{5'h10, 5'h11});

    // Home command 0x03 as command: long wait
    send(1'b0, 8'h03);
    wait_ready(n);
    check("home3_ready_cycles", n, 38);
    check_nibs("home3", '{5'h00, 5'h03});

    // Back-to-back with in_valid held high
    in_rs    = 1'b1;
    in_data  = 8'h41;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h42;
    wait_ready(n);
    check("b2b_first_cycles", n, 13);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_taken", in_ready, 1'b0);
    wait_ready(n);
    check("b2b_second_cycles", n, 13);
    check_nibs("b2b", '{5'h14, 5'h11, 5'h14, 5'h12});

    // Reset while E is high mid byte
    send(1'b1, 8'h48);
    n = 0;
    while (!lcd_e && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_e_seen", lcd_e, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_lcd_e", lcd_e, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_init_done", init_done, 1'b0);
    @(posedge clk); #1;
    clear_mon();
    rst_n = 1'b1;
    run_init("init2");

    // Controller still usable after re-init
    send(1'b0, 8'h80);
    wait_ready(n);
    check("cmd80_ready_cycles", n, 13);
    check_nibs("cmd80", '{5'h08, 5'h00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
